// File: rtl/bip_control_fsm.sv
// rtl/bip_control_fsm.sv - multi-cycle BIP control unit (FETCH/DECODE/EXEC/WAIT/HALT)
// Optional JMP/BEQZ support is compiled in with BIP_BRANCH_EN.
module bip_control_fsm #(
  parameter int NB_DATA            = 16,
  parameter int NB_OPCODE          = 5,
  parameter int NB_OPERAND         = 11,
  parameter int LOG2_N_INSMEM_ADDR = 11,
  parameter int LOG2_N_DATA_ADDR   = 10,
  parameter int RAM_RD_LATENCY     = 1
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_valid,
  input  logic [NB_DATA-1:0]            i_instruction,
  input  logic                          i_acc_zero,
  output logic [LOG2_N_INSMEM_ADDR-1:0] o_addr_instr,
  output logic [LOG2_N_DATA_ADDR-1:0]   o_data_addr,
  output logic [NB_OPERAND-1:0]         o_operand,
  output logic [1:0]                    o_sel_a,
  output logic                          o_sel_b,
  output logic                          o_op,
  output logic                          o_wr_acc,
  output logic                          o_wr_ram,
  output logic                          o_rd_ram,
  output logic                          o_halted,
  output logic                          o_illegal
);

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WAIT,
    ST_HALT
  } state_t;

  localparam logic [NB_OPCODE-1:0] OP_HALT     = NB_OPCODE'(0);
  localparam logic [NB_OPCODE-1:0] OP_STORE    = NB_OPCODE'(1);
  localparam logic [NB_OPCODE-1:0] OP_LOAD_VAR = NB_OPCODE'(2);
  localparam logic [NB_OPCODE-1:0] OP_LOAD_IMM = NB_OPCODE'(3);
  localparam logic [NB_OPCODE-1:0] OP_ADD_VAR  = NB_OPCODE'(4);
  localparam logic [NB_OPCODE-1:0] OP_ADD_IMM  = NB_OPCODE'(5);
  localparam logic [NB_OPCODE-1:0] OP_SUB_VAR  = NB_OPCODE'(6);
  localparam logic [NB_OPCODE-1:0] OP_SUB_IMM  = NB_OPCODE'(7);
  localparam logic [3:0]           WAIT_LAST   = 4'(RAM_RD_LATENCY);

  state_t                          state, state_n;
  logic [LOG2_N_INSMEM_ADDR-1:0]   pc, pc_n;
  logic [NB_DATA-1:0]              ir;
  logic [3:0]                      wait_cnt, wait_cnt_n;
  logic                            ir_load;
  logic [NB_OPCODE-1:0]            ir_opcode, dec_opcode;

  assign ir_opcode    = ir[NB_DATA-1:NB_OPERAND];
  assign dec_opcode   = i_instruction[NB_DATA-1:NB_OPERAND];
  assign o_addr_instr = pc;
  assign o_operand    = ir[NB_OPERAND-1:0];
  assign o_data_addr  = ir[LOG2_N_DATA_ADDR-1:0];

`ifdef BIP_BRANCH_EN
  localparam logic [NB_OPCODE-1:0] OP_JMP  = NB_OPCODE'(8);
  localparam logic [NB_OPCODE-1:0] OP_BEQZ = NB_OPCODE'(9);
  logic [LOG2_N_INSMEM_ADDR-1:0] br_target;
  if (LOG2_N_INSMEM_ADDR > NB_OPERAND) begin : g_zext
    assign br_target = {{(LOG2_N_INSMEM_ADDR-NB_OPERAND){1'b0}}, ir[NB_OPERAND-1:0]};
  end else begin : g_trunc
    assign br_target = ir[LOG2_N_INSMEM_ADDR-1:0];
  end
`else
  logic unused_acc_zero;
  assign unused_acc_zero = i_acc_zero;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= ST_FETCH;
      pc       <= '0;
      ir       <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      wait_cnt <= wait_cnt_n;
      if (ir_load) ir <= i_instruction;
    end
  end

  // Selects are decoded alongside the IR load so they are already valid in EXEC
  // and stay put through WAIT and until the next data-path instruction.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_sel_a <= 2'b00;
      o_sel_b <= 1'b0;
      o_op    <= 1'b0;
    end else if (ir_load) begin
      case (dec_opcode)
        OP_LOAD_VAR: begin o_sel_a <= 2'b00; o_sel_b <= 1'b0; o_op <= 1'b0; end
        OP_LOAD_IMM: begin o_sel_a <= 2'b01; o_sel_b <= 1'b1; o_op <= 1'b0; end
        OP_ADD_VAR:  begin o_sel_a <= 2'b10; o_sel_b <= 1'b0; o_op <= 1'b0; end
        OP_ADD_IMM:  begin o_sel_a <= 2'b10; o_sel_b <= 1'b1; o_op <= 1'b0; end
        OP_SUB_VAR:  begin o_sel_a <= 2'b10; o_sel_b <= 1'b0; o_op <= 1'b1; end
        OP_SUB_IMM:  begin o_sel_a <= 2'b10; o_sel_b <= 1'b1; o_op <= 1'b1; end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    wait_cnt_n = wait_cnt;
    ir_load    = 1'b0;
    o_wr_acc   = 1'b0;
    o_wr_ram   = 1'b0;
    o_rd_ram   = 1'b0;
    o_illegal  = 1'b0;
    o_halted   = (state == ST_HALT);
    // A stalled cycle changes nothing, so the state simply replays once i_valid returns.
    if (i_valid) begin
      case (state)
        ST_FETCH: state_n = ST_DECODE;
        ST_DECODE: begin
          ir_load = 1'b1;
          pc_n    = pc + 1'b1;
          state_n = ST_EXEC;
        end
        ST_EXEC: begin
          state_n = ST_FETCH;
          case (ir_opcode)
            OP_HALT: begin
              state_n  = ST_HALT;
              o_halted = 1'b1;
            end
            OP_STORE: o_wr_ram = 1'b1;
            OP_LOAD_VAR, OP_ADD_VAR, OP_SUB_VAR: begin
              o_rd_ram   = 1'b1;
              wait_cnt_n = 4'd1;
              state_n    = ST_WAIT;
            end
            OP_LOAD_IMM, OP_ADD_IMM, OP_SUB_IMM: o_wr_acc = 1'b1;
`ifdef BIP_BRANCH_EN
            OP_JMP: pc_n = br_target;
            OP_BEQZ: if (i_acc_zero) pc_n = br_target;
`endif
            default: o_illegal = 1'b1;
          endcase
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            o_wr_acc   = 1'b1;
            wait_cnt_n = 4'd0;
            state_n    = ST_FETCH;
          end else begin
            wait_cnt_n = wait_cnt + 4'd1;
          end
        end
        ST_HALT: state_n = ST_HALT;
        default: state_n = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_control_fsm.sv
// tb/tb_bip_control_fsm.sv - directed self-checking bench for bip_control_fsm
module tb_bip_control_fsm;
  localparam int LAT = 3;
`ifdef BIP_BRANCH_EN
  localparam logic BR = 1'b1;
`else
  localparam logic BR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, valid, acc_zero;
  logic [15:0] instr;
  logic [10:0] addr_instr;
  logic [9:0]  data_addr;
  logic [10:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b, op, wr_acc, wr_ram, rd_ram, halted, illegal;
  logic [15:0] imem [0:2047];
  int checks = 0;
  int errors = 0;
  int pulses;

  always #5 clk = ~clk;
  always @(posedge clk) instr <= imem[addr_instr];

  bip_control_fsm #(.RAM_RD_LATENCY(LAT)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .i_instruction(instr),
    .i_acc_zero(acc_zero), .o_addr_instr(addr_instr), .o_data_addr(data_addr),
    .o_operand(operand), .o_sel_a(sel_a), .o_sel_b(sel_b), .o_op(op),
    .o_wr_acc(wr_acc), .o_wr_ram(wr_ram), .o_rd_ram(rd_ram),
    .o_halted(halted), .o_illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] w);
    for (int i = 0; i < 2048; i++) imem[i] = w;
  endtask

  // Leaves the bench sampling cycle 1 (the first FETCH after reset release).
  task automatic do_reset();
    rst_n = 1'b0; valid = 1'b1; acc_zero = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_addr", 32'(addr_instr), 32'h0);
    chk("rst_wr_acc", 32'(wr_acc), 32'h0);
    chk("rst_sel_a", 32'(sel_a), 32'h0);
    chk("rst_operand", 32'(operand), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // LOAD_IMM 5; ADD_IMM 3; HALT
    fill(16'h0000);
    imem[0] = 16'h1805; imem[1] = 16'h2803; imem[2] = 16'h0000;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) tick();
      chk("t1_wr_acc", 32'(wr_acc), 32'(c == 3 || c == 6));
      if (c == 3) begin
        chk("t1_sel_a_imm", 32'(sel_a), 32'h1);
        chk("t1_operand5", 32'(operand), 32'h5);
      end
      if (c == 6) begin
        chk("t1_sel_a_alu", 32'(sel_a), 32'h2);
        chk("t1_sel_b", 32'(sel_b), 32'h1);
        chk("t1_op_add", 32'(op), 32'h0);
        chk("t1_operand3", 32'(operand), 32'h3);
      end
      chk("t1_halted", 32'(halted), 32'(c >= 9));
      if (c >= 9) chk("t1_pc_frozen", 32'(addr_instr), 32'h3);
    end

    // LOAD_VAR 0x2A with a 3-cycle RAM read
    imem[0] = 16'h102A; imem[1] = 16'h0000;
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) tick();
      chk("t2_rd_ram", 32'(rd_ram), 32'(c == 3));
      chk("t2_wr_acc", 32'(wr_acc), 32'(c == 6));
      if (c >= 3 && c <= 6) begin
        chk("t2_data_addr", 32'(data_addr), 32'h2A);
        chk("t2_sel_a", 32'(sel_a), 32'h0);
      end
      if (c == 7) chk("t2_next_fetch", 32'(addr_instr), 32'h1);
      chk("t2_halted", 32'(halted), 32'(c == 9));
    end

    // SUB_VAR with i_valid low for 4 cycles inside WAIT
    imem[0] = 16'h3015; imem[1] = 16'h0000;
    do_reset();
    pulses = 0;
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) begin
        @(negedge clk);
        valid = !(c >= 5 && c <= 8);
        #1;
      end
      pulses += int'(wr_acc);
      chk("t3_wr_acc", 32'(wr_acc), 32'(c == 10));
      chk("t3_rd_ram", 32'(rd_ram), 32'(c == 3));
      if (c == 10) begin
        chk("t3_op_sub", 32'(op), 32'h1);
        chk("t3_sel_a", 32'(sel_a), 32'h2);
        chk("t3_sel_b", 32'(sel_b), 32'h0);
        chk("t3_data_addr", 32'(data_addr), 32'h15);
      end
      if (c == 13) chk("t3_halted", 32'(halted), 32'h1);
    end
    chk("t3_pulse_count", 32'(pulses), 32'h1);

    // Undefined opcode 31
    imem[0] = 16'hF800; imem[1] = 16'h0000;
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) tick();
      chk("t4_illegal", 32'(illegal), 32'(c == 3));
      chk("t4_strobes", 32'({wr_acc, wr_ram, rd_ram}), 32'h0);
      if (c == 4) chk("t4_pc_adv", 32'(addr_instr), 32'h1);
      if (c == 7) chk("t4_halted", 32'(halted), 32'h1);
    end

    // PC wrap from 2047 to 0 over 2048 LOAD_IMM instructions
    fill(16'h1801);
    do_reset();
    pulses = 0;
    for (int c = 1; c <= 6145; c++) begin
      if (c > 1) tick();
      pulses += int'(wr_acc);
      if (c == 6142) chk("t5_pc_2047", 32'(addr_instr), 32'h7FF);
      if (c == 6145) chk("t5_pc_wrap", 32'(addr_instr), 32'h0);
    end
    chk("t5_wr_acc_count", 32'(pulses), 32'd2048);

    // BEQZ 0x100, taken and not taken
    fill(16'h0000);
    imem[0] = 16'h4900;
    for (int z = 1; z >= 0; z--) begin
      do_reset();
      acc_zero = z[0];
      for (int c = 1; c <= 4; c++) begin
        if (c > 1) tick();
        if (c == 3) chk("t6_illegal", 32'(illegal), 32'(!BR));
        if (c == 4) chk("t6_next_fetch", 32'(addr_instr), (BR && z == 1) ? 32'h100 : 32'h1);
      end
    end

    // Asynchronous reset in the middle of a RAM wait
    imem[0] = 16'h102A;
    do_reset();
    for (int c = 2; c <= 5; c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_abort_addr", 32'(data_addr), 32'h0);
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      pulses += int'(wr_acc) + int'(rd_ram);
    end
    chk("t7_no_strobe", 32'(pulses), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
